cnn_3_3: RTL and testbench

//  - One 3x3 convolution output per clock: signed int8 dot product of a 3x3 feature window and a 3x3 kernel.
//  - Adds a 32-bit bias, then requantizes to int8 with a fixed-point multiplier (Scale) and a right shift (Shift).
//  - Fully pipelined, one result per clock. Sits behind the window/line-buffer logic as the per-pixel compute element.

---
 rtl/cnn_pkg.sv | 51 +++++
 rtl/cnn_dot9.sv | 43 ++++
 rtl/cnn_3_3.sv | 95 +++++++++
 tb/tb_cnn_3_3.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared widths, tap vectors and stage records for the 3x3 conv compute element.
// Imported by cnn_dot9 and cnn_3_3; holds no logic.
package cnn_pkg;

  localparam int DATA_W  = 8;
  localparam int TAPS    = 9;
  localparam int BIAS_W  = 32;
  localparam int SCALE_W = 32;
  localparam int SHIFT_W = 8;
  localparam int SH_W    = 6;
  localparam int MUL_W   = 2 * DATA_W;
  localparam int ACC_W   = 19;
  localparam int SUM_W   = 33;
  localparam int PROD_W  = 65;
  localparam int RND_W   = PROD_W + 1;

  typedef logic signed [DATA_W-1:0] int8_t;
  typedef int8_t [TAPS-1:0]         taps_t;
  typedef logic signed [MUL_W-1:0]  mul_t;
  typedef mul_t [TAPS-1:0]          muls_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [RND_W-1:0]  rnd_t;

  typedef struct packed {
    logic signed [BIAS_W-1:0] bias;
    logic [SCALE_W-1:0]       scale;
    logic [SH_W-1:0]          shift;
  } s1_t;

  typedef struct packed {
    sum_t               sum;
    logic [SCALE_W-1:0] scale;
    logic [SH_W-1:0]    shift;
  } s2_t;

  typedef struct packed {
    prod_t           prod;
    logic [SH_W-1:0] shift;
  } s3_t;

  // Shift amounts above 63 saturate to 63.
  function automatic logic [SH_W-1:0] clamp_shift(
    input logic [SHIFT_W-1:0] sh
  );
    if (sh > SHIFT_W'(63)) return SH_W'(63);
    return sh[SH_W-1:0];
  endfunction

endpackage

// File: rtl/cnn_dot9.sv
// Nine-tap signed int8 dot product: registered products, combinational adder tree.
// Ports: clk_i, rst_i (sync, active-high), feat_i/wgt_i tap vectors, acc_o 19-bit sum.
module cnn_dot9
  import cnn_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  taps_t feat_i,
  input  taps_t wgt_i,
  output acc_t  acc_o
);

  muls_t mul_q;
  muls_t mul_d;

  always_comb begin
    mul_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      mul_d[k] = mul_t'(feat_i[k]) * mul_t'(wgt_i[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_q <= '0;
    end else begin
      mul_q <= mul_d;
    end
  end

  // Pairwise first level, then fold the four pairs and the odd tap.
  acc_t pair0, pair1, pair2, pair3;

  always_comb begin
    pair0 = acc_t'(mul_q[0]) + acc_t'(mul_q[1]);
    pair1 = acc_t'(mul_q[2]) + acc_t'(mul_q[3]);
    pair2 = acc_t'(mul_q[4]) + acc_t'(mul_q[5]);
    pair3 = acc_t'(mul_q[6]) + acc_t'(mul_q[7]);
    acc_o = (pair0 + pair1) + (pair2 + pair3)
          + acc_t'(mul_q[8]);
  end

endmodule

// File: rtl/cnn_3_3.sv
// 3x3 conv element: dot9 + bias, scale, rounded shift, int8 saturate; 4-edge latency.
// Ports: CLK, RSTN (sync active-high), Feature/Weight 72b, BIAS, Scale, Shift, RESULT int8.
module cnn_3_3
  import cnn_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic [TAPS*DATA_W-1:0]   Feature,
  input  logic [TAPS*DATA_W-1:0]   Weight,
  input  logic [BIAS_W-1:0]        BIAS,
  input  logic [SCALE_W-1:0]       Scale,
  input  logic [SHIFT_W-1:0]       Shift,
  output logic [DATA_W-1:0]        RESULT
);

  // RSTN is active-high despite its name.
  logic rst;
  assign rst = RSTN;

  acc_t acc;

  cnn_dot9 u_dot9 (
    .clk_i  (CLK),
    .rst_i  (rst),
    .feat_i (taps_t'(Feature)),
    .wgt_i  (taps_t'(Weight)),
    .acc_o  (acc)
  );

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;
  logic [DATA_W-1:0] result_q, result_d;

  always_comb begin
    s1_d       = '0;
    s1_d.bias  = BIAS;
    s1_d.scale = Scale;
    s1_d.shift = clamp_shift(Shift);
  end

  always_comb begin
    s2_d       = '0;
    s2_d.sum   = sum_t'(acc) + sum_t'(s1_q.bias);
    s2_d.scale = s1_q.scale;
    s2_d.shift = s1_q.shift;
  end

  // Scale is unsigned: zero-extend before the signed multiply.
  // The true product fits in 65 bits, so truncation is exact.
  always_comb begin
    s3_d       = '0;
    s3_d.prod  = prod_t'(s2_q.sum)
               * prod_t'($signed({1'b0, s2_q.scale}));
    s3_d.shift = s2_q.shift;
  end

  rnd_t inc;
  rnd_t rnd;

  // One extra bit keeps prod + half-LSB from wrapping.
  always_comb begin
    inc = '0;
    if (s3_q.shift != '0) begin
      inc = rnd_t'(1) <<< (s3_q.shift - SH_W'(1));
    end
    rnd = (rnd_t'(s3_q.prod) + inc) >>> s3_q.shift;
  end

  always_comb begin
    result_d = rnd[DATA_W-1:0];
    unique case (1'b1)
      (rnd > rnd_t'(127)):  result_d = 8'h7F;
      (rnd < rnd_t'(-128)): result_d = 8'h80;
      default:              result_d = rnd[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      result_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      result_q <= result_d;
    end
  end

  assign RESULT = result_q;

endmodule

// File: tb/tb_cnn_3_3.sv
// Directed bench for cnn_3_3: hand-computed vectors through a 4-slot delay line.
// Covers reset, unity, saturation, rounding, shift clamp, streaming, mid-stream reset.
module tb_cnn_3_3;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [71:0] Feature;
  logic [71:0] Weight;
  logic [31:0] BIAS;
  logic [31:0] Scale;
  logic [7:0]  Shift;
  logic [7:0]  RESULT;

  int n_cmp = 0;
  int n_err = 0;

  cnn_3_3 dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .Feature (Feature),
    .Weight  (Weight),
    .BIAS    (BIAS),
    .Scale   (Scale),
    .Shift   (Shift),
    .RESULT  (RESULT)
  );

  always #5 CLK = ~CLK;

  string      tg[4];
  logic [7:0] ex[4];
  bit         pv[4];

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] rep(input logic [7:0] b);
    return {9{b}};
  endfunction

  // Drive one sample, clock it in, then age the delay line;
  // slot 3 is the sample captured three edges ago.
  task automatic issue(input string tag, input logic [71:0] f,
                       input logic [71:0] w, input logic [31:0] b,
                       input logic [31:0] s, input logic [7:0] sh,
                       input logic [7:0] e, input bit v);
    Feature = f; Weight = w; BIAS = b; Scale = s; Shift = sh;
    @(posedge CLK);
    #1;
    for (int i = 3; i > 0; i--) begin
      tg[i] = tg[i-1]; ex[i] = ex[i-1]; pv[i] = pv[i-1];
    end
    tg[0] = tag; ex[0] = e; pv[0] = v;
    if (pv[3]) chk(tg[3], RESULT, ex[3]);
  endtask

  task automatic pulse_reset();
    RSTN = 1'b1;
    Feature = rep(8'h7F); Weight = rep(8'h7F);
    BIAS = 32'd1000; Scale = 32'h8000_0000; Shift = 8'd31;
    @(posedge CLK);
    #1;
    chk("rst_edge", RESULT, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tg[i] = "rst_flush"; ex[i] = 8'h00; pv[i] = 1'b1;
    end
    RSTN = 1'b0;
  endtask

  localparam logic [31:0] S31 = 32'h8000_0000;

  logic [71:0] seq;
  logic [71:0] mix;

  initial begin
    for (int i = 0; i < 4; i++) begin
      tg[i] = ""; ex[i] = 8'h00; pv[i] = 1'b0;
    end
    for (int k = 0; k < 9; k++) seq[8*k +: 8] = 8'(k + 1);
    mix = 72'h0;
    mix[7:0]   = 8'h10;
    mix[15:8]  = 8'hF0;
    mix[71:64] = 8'h03;
    RSTN = 1'b1;
    Feature = '0; Weight = '0; BIAS = '0; Scale = '0; Shift = '0;
    repeat (2) @(posedge CLK);
    #1;
    pulse_reset();

    issue("zero", 72'h0, rep(8'h55), 32'd0, S31, 8'd31, 8'h00, 1);
    issue("unity", rep(8'h01), rep(8'h01), 32'd0, S31, 8'd31, 8'h09, 1);
    issue("pos_sat", rep(8'h7F), rep(8'h7F), 32'd0, S31, 8'd31, 8'h7F, 1);
    issue("neg_sat", rep(8'h80), rep(8'h7F), 32'd0, S31, 8'd31, 8'h80, 1);
    issue("rnd_p3", 72'h0, rep(8'h11), 32'd3, S31, 8'd32, 8'h02, 1);
    issue("rnd_m3", 72'h0, rep(8'h11), -32'sd3, S31, 8'd32, 8'hFF, 1);
    issue("rnd_p1", 72'h0, rep(8'h11), 32'd1, S31, 8'd32, 8'h01, 1);
    issue("sh0", 72'h0, rep(8'h11), 32'd0, 32'd0, 8'd0, 8'h00, 1);
    // taps 1..9 times 2 -> 90; +11 -> 101; /2 = 50.5 rounds up.
    issue("seq", seq, rep(8'h02), 32'd11, S31, 8'd32, 8'd51, 1);
    // 9*5*-3 = -135; /4 = -33.75 -> -34.
    issue("neg_rnd", rep(8'h05), rep(8'hFD), 32'd0, S31, 8'd33, 8'hDE, 1);
    // (2^31-1)(2^32-1) >>> 63 with rounding -> 1; Shift 200 clamps to 63.
    issue("sh_clamp", 72'h0, 72'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
          8'd200, 8'h01, 1);
    // 16*1 + -16*1 + 3*1 = 3; Shift 0, Scale 1 -> 3.
    issue("mix_sh0", mix, rep(8'h01), 32'd0, 32'd1, 8'd0, 8'h03, 1);
    // bias only: -100 at unity scale.
    issue("bias_neg", 72'h0, 72'h0, -32'sd100, S31, 8'd31, 8'h9C, 1);

    issue("st0", rep(8'h02), rep(8'h03), 32'd0, S31, 8'd31, 8'd54, 1);
    issue("st1", rep(8'h01), rep(8'hFF), 32'd0, S31, 8'd31, 8'hF7, 1);
    issue("st2", 72'h0, 72'h0, 32'd77, S31, 8'd31, 8'd77, 1);
    issue("st3", rep(8'h04), rep(8'h02), 32'd0, S31, 8'd32, 8'd36, 1);
    issue("st4", rep(8'h0A), rep(8'h0A), -32'sd850, S31, 8'd31, 8'd50, 1);

    issue("pre0", rep(8'h7F), rep(8'h7F), 32'd0, S31, 8'd31, 8'h7F, 1);
    issue("pre1", rep(8'h01), rep(8'h01), 32'd0, S31, 8'd31, 8'h09, 1);
    pulse_reset();
    issue("post0", 72'h0, 72'h0, 32'd5, S31, 8'd31, 8'd5, 1);
    issue("post1", rep(8'h01), rep(8'h02), 32'd0, S31, 8'd31, 8'd18, 1);

    repeat (4) issue("drain", 72'h0, 72'h0, 32'd0, S31, 8'd31, 8'h00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
